// File: rtl/hilo_unit_pkg.sv
// Shared constants and state encoding for the HI/LO multiply/divide unit.
package hilo_unit_pkg;
  localparam int WIDTH     = 24;
  localparam int DIV_STEPS = 24;

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_t;
endpackage

// File: rtl/hilo_unit_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, and keep or restore.
module div_step #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;

  assign shifted = {r[WIDTH-2:0], q[WIDTH-1]};
  // The extra top bit acts as the sign of the trial difference.
  assign trial   = {1'b0, shifted} - {1'b0, d};

  always_comb begin
    r_next = shifted;
    q_next = {q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      r_next = trial[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO registers fed by the ALU product or by an iterative
// 24-step unsigned restoring divider.
module hilo_unit #(
  parameter int WIDTH = 24
) (
  input  logic               Clock,
  input  logic               ResetN,
  input  logic [2*WIDTH-1:0] MulIn,
  input  logic               MulWrite,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               DivStart,
  output logic [WIDTH-1:0]   HIOut,
  output logic [WIDTH-1:0]   LOOut,
  output logic               Busy,
  output logic               Done,
  output logic               DivByZero
);
  import hilo_unit_pkg::*;

  state_t           state_reg;
  logic [WIDTH-1:0] r_reg, q_reg, d_reg;
  logic [WIDTH-1:0] r_next, q_next;
  logic [4:0]       cnt_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             done_reg, dbz_reg;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .r      (r_reg),
    .q      (q_reg),
    .d      (d_reg),
    .r_next (r_next),
    .q_next (q_next)
  );

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_reg <= IDLE;
      r_reg     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
      dbz_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // A product write wins over a simultaneous division request.
          if (MulWrite) begin
            hi_reg <= MulIn[2*WIDTH-1:WIDTH];
            lo_reg <= MulIn[WIDTH-1:0];
          end else if (DivStart) begin
            if (B == '0) begin
              hi_reg   <= A;
              lo_reg   <= '1;
              dbz_reg  <= 1'b1;
              done_reg <= 1'b1;
            end else begin
              r_reg     <= '0;
              q_reg     <= A;
              d_reg     <= B;
              cnt_reg   <= '0;
              dbz_reg   <= 1'b0;
              state_reg <= DIV;
            end
          end
        end
        DIV: begin
          r_reg   <= r_next;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == 5'(DIV_STEPS - 1)) begin
            hi_reg    <= r_next;
            lo_reg    <= q_next;
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Busy      = (state_reg == DIV);
  assign HIOut     = hi_reg;
  assign LOOut     = lo_reg;
  assign Done      = done_reg;
  assign DivByZero = dbz_reg;
endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit: reset, product capture, division,
// divide-by-zero, ignored requests and asynchronous abort.
module tb_hilo_unit;
  logic        Clock = 1'b0;
  logic        ResetN = 1'b0;
  logic [47:0] MulIn = '0;
  logic        MulWrite = 1'b0;
  logic [23:0] A = '0;
  logic [23:0] B = '0;
  logic        DivStart = 1'b0;
  logic [23:0] HIOut, LOOut;
  logic        Busy, Done, DivByZero;

  int passed = 0;
  int total  = 0;

  hilo_unit #(.WIDTH(24)) dut (
    .Clock     (Clock),
    .ResetN    (ResetN),
    .MulIn     (MulIn),
    .MulWrite  (MulWrite),
    .A         (A),
    .B         (B),
    .DivStart  (DivStart),
    .HIOut     (HIOut),
    .LOOut     (LOOut),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %-22s observed %h expected %h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start a division at the next negedge and watch it for 30 cycles.
  task automatic run_div(input string tag, input logic [23:0] a, input logic [23:0] b,
                         input logic [23:0] exp_q, input logic [23:0] exp_r, input bit inject);
    int busy_n = 0;
    int done_n = 0;
    bit leaked = 1'b0;
    logic [23:0] hi_s = '0, lo_s = '0, hi_pre, lo_pre;
    @(negedge Clock);
    hi_pre = HIOut;
    lo_pre = LOOut;
    A = a; B = b; DivStart = 1'b1;
    @(negedge Clock);
    DivStart = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (Busy) busy_n++;
      if (Done) begin
        done_n++;
        hi_s = HIOut;
        lo_s = LOOut;
      end
      if (HIOut == 24'hABCDEF || LOOut == 24'h123456) leaked = 1'b1;
      if (i == 10) begin
        chk({tag, " hi_hold"}, 48'(HIOut), 48'(hi_pre));
        chk({tag, " lo_hold"}, 48'(LOOut), 48'(lo_pre));
      end
      if (inject && i == 3) begin
        MulWrite = 1'b1; MulIn = 48'hABCDEF_123456;
        DivStart = 1'b1; A = 24'd1; B = 24'd1;
      end
      if (inject && i == 20) begin
        MulWrite = 1'b0; DivStart = 1'b0;
      end
      @(negedge Clock);
    end
    chk({tag, " busy_cycles"}, 48'(busy_n), 48'd24);
    chk({tag, " done_pulses"}, 48'(done_n), 48'd1);
    chk({tag, " quotient"}, 48'(lo_s), 48'(exp_q));
    chk({tag, " remainder"}, 48'(hi_s), 48'(exp_r));
    if (inject) chk({tag, " no_leak"}, 48'(leaked), 48'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge Clock);
    chk("rst hi", 48'(HIOut), 48'd0);
    chk("rst lo", 48'(LOOut), 48'd0);
    chk("rst busy", 48'(Busy), 48'd0);
    chk("rst done", 48'(Done), 48'd0);
    chk("rst dbz", 48'(DivByZero), 48'd0);
    ResetN = 1'b1;
    repeat (5) @(negedge Clock);
    chk("idle hi", 48'(HIOut), 48'd0);
    chk("idle lo", 48'(LOOut), 48'd0);
    chk("idle busy", 48'(Busy), 48'd0);

    // Product capture
    MulWrite = 1'b1; MulIn = 48'h000123_456789;
    @(negedge Clock);
    MulWrite = 1'b0;
    chk("mul hi", 48'(HIOut), 48'h000123);
    chk("mul lo", 48'(LOOut), 48'h456789);

    // Divisions
    run_div("div100_7", 24'd100, 24'd7, 24'd14, 24'd2, 1'b0);
    chk("done_cleared", 48'(Done), 48'd0);
    run_div("divmax_1", 24'hFFFFFF, 24'd1, 24'hFFFFFF, 24'd0, 1'b0);

    // Divide by zero
    @(negedge Clock);
    A = 24'd5; B = 24'd0; DivStart = 1'b1;
    @(negedge Clock);
    DivStart = 1'b0;
    chk("dbz hi", 48'(HIOut), 48'd5);
    chk("dbz lo", 48'(LOOut), 48'hFFFFFF);
    chk("dbz flag", 48'(DivByZero), 48'd1);
    chk("dbz done", 48'(Done), 48'd1);
    chk("dbz busy", 48'(Busy), 48'd0);
    @(negedge Clock);
    chk("dbz done_drop", 48'(Done), 48'd0);
    chk("dbz busy2", 48'(Busy), 48'd0);
    chk("dbz flag_hold", 48'(DivByZero), 48'd1);
    A = 24'd9; B = 24'd3; DivStart = 1'b1;
    @(negedge Clock);
    DivStart = 1'b0;
    chk("dbz cleared", 48'(DivByZero), 48'd0);
    repeat (26) @(negedge Clock);
    chk("div9_3 q", 48'(LOOut), 48'd3);
    chk("div9_3 r", 48'(HIOut), 48'd0);

    // Requests during a division are ignored
    run_div("inject", 24'd100, 24'd7, 24'd14, 24'd2, 1'b1);

    // MulWrite beats DivStart in IDLE
    MulWrite = 1'b1; MulIn = 48'h00AAAA_00BBBB;
    DivStart = 1'b1; A = 24'd20; B = 24'd3;
    @(negedge Clock);
    MulWrite = 1'b0; DivStart = 1'b0;
    chk("both hi", 48'(HIOut), 48'h00AAAA);
    chk("both lo", 48'(LOOut), 48'h00BBBB);
    chk("both busy", 48'(Busy), 48'd0);
    @(negedge Clock);
    chk("both busy2", 48'(Busy), 48'd0);

    // Asynchronous abort mid-division
    A = 24'd100; B = 24'd7; DivStart = 1'b1;
    @(negedge Clock);
    DivStart = 1'b0;
    repeat (9) @(negedge Clock);
    chk("abort busy_before", 48'(Busy), 48'd1);
    #2 ResetN = 1'b0;
    #1;
    chk("abort busy", 48'(Busy), 48'd0);
    chk("abort hi", 48'(HIOut), 48'd0);
    chk("abort lo", 48'(LOOut), 48'd0);
    chk("abort done", 48'(Done), 48'd0);
    @(negedge Clock);
    ResetN = 1'b1;
    run_div("div50_6", 24'd50, 24'd6, 24'd8, 24'd2, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
